sweep_ctrl: RTL and testbench

- Control stage placed directly upstream of the 8-bit up/down counter. Drives that counter's ld, d_in, mode and clear inputs, and reads its count output back.
- Makes the counter sweep as a triangle wave between programmable bounds lo and hi, for a programmed number of sweeps or continuously.
- Freezes the counter between runs and reports busy, done and a bounds error.

---
 rtl/sweep_pkg.sv | 21 ++
 rtl/sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_sweep_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sweep_pkg : shared types and defaults for the sweep controller     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sweep_pkg;

  localparam int W_DEF     = 8;
  localparam int SW_DEF    = 4;
  // A sweep count of this value means run until stopped
  localparam int CONT_CODE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    UP   = 2'd2,
    DOWN = 2'd3
  } state_e;

endpackage : sweep_pkg
`default_nettype wire

// File: rtl/sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sweep_ctrl : drives an external up/down counter as a triangle wave |
// | between captured bounds, for N sweeps or continuously.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic [SW-1:0] cycles,
  input  logic [W-1:0]  count,
  output logic          ld,
  output logic [W-1:0]  d_in,
  output logic          mode,
  output logic          cnt_clr,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_e        state_q, state_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [SW-1:0] cyc_q, cyc_d;
  logic [SW-1:0] sweep_n_q, sweep_n_d;
  logic          err_q, err_d;

  logic [SW-1:0] w_sweep_inc;
  logic          w_last_sweep;

  assign w_sweep_inc  = sweep_n_q + SW'(1);
  assign w_last_sweep = (cyc_q != SW'(CONT_CODE)) && (w_sweep_inc == cyc_q);
  assign err          = err_q;

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cyc_d     = cyc_q;
    sweep_n_d = sweep_n_q;
    err_d     = err_q;
    ld        = 1'b0;
    d_in      = '0;
    mode      = 1'b0;
    cnt_clr   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    if (clr) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Reloading the counter with its own value freezes it
          ld   = 1'b1;
          d_in = count;
          if (!stop && start) begin
            if (lo >= hi) begin
              err_d = 1'b1;
            end else begin
              lo_d      = lo;
              hi_d      = hi;
              cyc_d     = cycles;
              err_d     = 1'b0;
              sweep_n_d = '0;
              state_d   = LOAD;
            end
          end
        end

        LOAD, UP, DOWN: begin
          busy = 1'b1;
          if (stop) begin
            ld        = 1'b1;
            d_in      = count;
            sweep_n_d = '0;
            state_d   = IDLE;
          end else if (state_q == LOAD) begin
            ld      = 1'b1;
            d_in    = lo_q;
            state_d = UP;
          end else if (state_q == UP) begin
            if (count == hi_q) begin
              mode    = 1'b0;
              state_d = DOWN;
            end else begin
              mode = 1'b1;
            end
          end else begin
            if (count == lo_q) begin
              if (w_last_sweep) begin
                ld      = 1'b1;
                d_in    = lo_q;
                done    = 1'b1;
                state_d = IDLE;
              end else begin
                mode      = 1'b1;
                sweep_n_d = w_sweep_inc;
                state_d   = UP;
              end
            end else begin
              mode = 1'b0;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      cyc_q     <= '0;
      sweep_n_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cyc_q     <= cyc_d;
      sweep_n_q <= sweep_n_d;
      err_q     <= err_d;
    end
  end

endmodule : sweep_ctrl
`default_nettype wire

// File: tb/tb_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sweep_ctrl : sweep controller closed around an up/down counter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sweep_ctrl;

  logic       clk = 1'b0;
  logic       clr, start, stop;
  logic [7:0] lo_i, hi_i;
  logic [3:0] cycles_i;
  logic [7:0] count;
  logic       ld, mode, cnt_clr, busy, done, err;
  logic [7:0] d_in;

  typedef struct {
    logic [7:0] cnt;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sweep_ctrl u_dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .stop   (stop),
    .lo     (lo_i),
    .hi     (hi_i),
    .cycles (cycles_i),
    .count  (count),
    .ld     (ld),
    .d_in   (d_in),
    .mode   (mode),
    .cnt_clr(cnt_clr),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  // Counter beside the controller: ld over clear over direction
  always @(posedge clk) begin
    if (ld)           count <= d_in;
    else if (cnt_clr) count <= 8'd0;
    else if (mode)    count <= count + 8'd1;
    else              count <= count - 8'd1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_sweeps(input int lo, input int hi, input int n, input bit finite);
    exp_t e;
    e.cnt = 8'(lo); e.dn = 1'b0; sb.push_back(e);
    for (int s = 0; s < n; s++) begin
      for (int v = lo + 1; v <= hi; v++) begin
        e.cnt = 8'(v); e.dn = 1'b0; sb.push_back(e);
      end
      for (int v = hi - 1; v >= lo; v--) begin
        e.cnt = 8'(v); e.dn = finite && (s == n - 1) && (v == lo); sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
        return;
      end
      e = sb.pop_front();
      chk("count", 32'(count), 32'(e.cnt));
      chk("done", 32'(done), 32'(e.dn));
      chk("busy_run", 32'(busy), 32'd1);
    end
  endtask

  // Drives a start, then scrambles the bound inputs to prove they were captured
  task automatic launch(input int lo, input int hi, input int cyc);
    start = 1'b1; lo_i = 8'(lo); hi_i = 8'(hi); cycles_i = 4'(cyc);
    tick();
    start = 1'b0; lo_i = 8'd77; hi_i = 8'd11; cycles_i = 4'd0;
    chk("busy_load", 32'(busy), 32'd1);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; stop = 1'b0;
    lo_i = '0; hi_i = '0; cycles_i = '0;
    tick(); tick();
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd1);
    chk("rst_ld", 32'(ld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    clr = 1'b0;
    tick();
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_ld", 32'(ld), 32'd1);
    chk("idle_count", 32'(count), 32'd0);

    // Basic single sweep
    launch(3, 6, 1);
    push_sweeps(3, 6, 1, 1'b1);
    drain(7);
    tick();
    chk("basic_hold", 32'(count), 32'd3);
    chk("basic_busy", 32'(busy), 32'd0);
    chk("basic_done", 32'(done), 32'd0);

    // Three sweeps
    launch(0, 2, 3);
    push_sweeps(0, 2, 3, 1'b1);
    drain(13);
    tick();
    chk("multi_hold", 32'(count), 32'd0);
    chk("multi_busy", 32'(busy), 32'd0);

    // Continuous: never completes on its own
    launch(0, 2, 0);
    push_sweeps(0, 2, 26, 1'b0);
    drain(105);
    chk("cont_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_count", 32'(count), 32'd0);

    // Bounds error, then recovery
    start = 1'b1; lo_i = 8'd9; hi_i = 8'd9; cycles_i = 4'd1;
    tick();
    start = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_count", 32'(count), 32'd0);
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    launch(1, 4, 1);
    chk("err_cleared", 32'(err), 32'd0);
    push_sweeps(1, 4, 1, 1'b1);
    drain(7);
    tick();

    // Abort at count 5 while rising
    launch(2, 8, 0);
    push_sweeps(2, 8, 1, 1'b0);
    drain(4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    sb.delete();
    chk("abort_count", 32'(count), 32'd5);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_hold", 32'(count), 32'd5);

    // stop has priority over start in IDLE
    stop = 1'b1; start = 1'b1; lo_i = 8'd1; hi_i = 8'd5; cycles_i = 4'd1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("ss_busy", 32'(busy), 32'd0);
    chk("ss_count", 32'(count), 32'd5);
    tick();
    chk("ss_count2", 32'(count), 32'd5);

    // Edge bounds
    launch(254, 255, 1);
    push_sweeps(254, 255, 1, 1'b1);
    drain(3);
    tick();
    chk("top_hold", 32'(count), 32'd254);
    launch(0, 1, 1);
    push_sweeps(0, 1, 1, 1'b1);
    drain(3);
    tick();
    chk("bot_hold", 32'(count), 32'd0);

    // Reset while descending
    launch(3, 6, 2);
    push_sweeps(3, 6, 2, 1'b1);
    drain(5);
    clr = 1'b1;
    tick();
    chk("mid_cnt_clr", 32'(cnt_clr), 32'd1);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_err", 32'(err), 32'd0);
    clr = 1'b0;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mid_no_done", 32'(done), 32'd0);
      chk("mid_idle", 32'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sweep_ctrl
`default_nettype wire
